// File: rtl/gpio_sel_sequencer.sv
// Per-pin GPIO source-select sequencer. A commit tristates the pins whose select changes, then applies all selects at once.
// Optional build macro GPIO_SEL_LOCK_EN adds a sticky lock bit at CTRL[1].
module gpio_sel_sequencer #(
   parameter int GUARD_CYCLES = 4,
   parameter int NUM_SRC      = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_wr,
   input  logic        reg_rd,
   input  logic [2:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   output logic [31:0] reg_rdata,
   output logic        reg_ack,
   output logic [31:0] pin_0to7_sel,
   output logic [31:0] pin_8to15_sel,
   output logic [31:0] pin_16to23_sel,
   output logic [31:0] pin_24to31_sel,
   output logic [23:0] pin_32to37_sel,
   output logic [37:0] force_oeb,
   output logic        busy,
   output logic        commit_done
);

   localparam int NUM_PINS = 38;
   localparam int SEL_W    = 4 * NUM_PINS;
   localparam int CNT_W    = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
   localparam logic [4:0] NUM_SRC_W = 5'(NUM_SRC);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GUARD,
      ST_APPLY
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0]   shadow_q, shadow_d;
   logic [SEL_W-1:0]   active_q, active_d;
   logic [37:0]        force_oeb_q, force_oeb_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ack_q, ack_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_range_q, err_range_d;
   logic               err_busy_q, err_busy_d;
   logic               locked;
   logic [37:0]        changed;
   logic               range_bad;
   logic               sel_blocked;
   logic [31:0]        rd_mux;

`ifdef GPIO_SEL_LOCK_EN
   logic lock_q, lock_d;
   assign locked = lock_q;
`else
   assign locked = 1'b0;
`endif

   assign sel_blocked = busy_q | locked;

   always_comb begin
      changed   = '0;
      range_bad = 1'b0;
      for (int p = 0; p < NUM_PINS; p++) begin
         changed[p] = (shadow_q[4*p +: 4] != active_q[4*p +: 4]);
         if ({1'b0, shadow_q[4*p +: 4]} >= NUM_SRC_W) range_bad = 1'b1;
      end
   end

   always_comb begin
      case (reg_addr)
         3'd0:    rd_mux = shadow_q[31:0];
         3'd1:    rd_mux = shadow_q[63:32];
         3'd2:    rd_mux = shadow_q[95:64];
         3'd3:    rd_mux = shadow_q[127:96];
         3'd4:    rd_mux = {8'h00, shadow_q[151:128]};
         3'd5:    rd_mux = {30'b0, locked, 1'b0};
         3'd6:    rd_mux = {29'b0, err_range_q, err_busy_q, busy_q};
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      // NOTE: every _d starts from its hold value so no path through this block can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      force_oeb_d = force_oeb_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_range_d = err_range_q;
      err_busy_d  = err_busy_q;
      ack_d       = reg_wr | reg_rd;
      rdata_d     = (reg_rd && !reg_wr) ? rd_mux : '0;
`ifdef GPIO_SEL_LOCK_EN
      lock_d      = lock_q;
`endif

      case (state_q)
         ST_GUARD: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_APPLY;
         end
         ST_APPLY: begin
            active_d    = shadow_q;
            force_oeb_d = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
         end
         default: ;
      endcase

      if (reg_wr && reg_addr <= 3'd4) begin
         if (sel_blocked) begin
            err_busy_d = 1'b1;
         end else begin
            case (reg_addr)
               3'd0:    shadow_d[31:0]    = reg_wdata;
               3'd1:    shadow_d[63:32]   = reg_wdata;
               3'd2:    shadow_d[95:64]   = reg_wdata;
               3'd3:    shadow_d[127:96]  = reg_wdata;
               default: shadow_d[151:128] = reg_wdata[23:0];
            endcase
         end
      end

      if (reg_wr && reg_addr == 3'd5) begin
         // Error clear lands first so a commit in the same write can re-flag.
         if (reg_wdata[2]) begin
            err_range_d = 1'b0;
            err_busy_d  = 1'b0;
         end
`ifdef GPIO_SEL_LOCK_EN
         if (reg_wdata[1]) lock_d = 1'b1;
`endif
         if (reg_wdata[0]) begin
            if (sel_blocked) begin
               err_busy_d = 1'b1;
            end else if (range_bad) begin
               err_range_d = 1'b1;
            end else begin
               force_oeb_d = changed;
               cnt_d       = CNT_W'(GUARD_CYCLES);
               busy_d      = 1'b1;
               state_d     = (GUARD_CYCLES == 0 || changed == '0) ? ST_APPLY : ST_GUARD;
            end
         end
      end
   end

   // NOTE: shadow and active selects are plain registers with a defined reset value, not RAM, so they reset with everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shadow_q    <= '0;
         active_q    <= '0;
         force_oeb_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         err_range_q <= 1'b0;
         err_busy_q  <= 1'b0;
`ifdef GPIO_SEL_LOCK_EN
         lock_q      <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         force_oeb_q <= force_oeb_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         err_range_q <= err_range_d;
         err_busy_q  <= err_busy_d;
`ifdef GPIO_SEL_LOCK_EN
         lock_q      <= lock_d;
`endif
      end
   end

   assign pin_0to7_sel   = active_q[31:0];
   assign pin_8to15_sel  = active_q[63:32];
   assign pin_16to23_sel = active_q[95:64];
   assign pin_24to31_sel = active_q[127:96];
   assign pin_32to37_sel = active_q[151:128];
   assign force_oeb      = force_oeb_q;
   assign busy           = busy_q;
   assign commit_done    = done_q;
   assign reg_ack        = ack_q;
   assign reg_rdata      = rdata_q;

endmodule

// File: tb/tb_gpio_sel_sequencer.sv
// Self-checking bench for gpio_sel_sequencer: directed scenarios plus randomized select programming against a pin-array model.
module tb_gpio_sel_sequencer;

   localparam int G    = 4;
   localparam int NSRC = 13;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_wr, reg_rd;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic [31:0] pin_0to7_sel, pin_8to15_sel, pin_16to23_sel, pin_24to31_sel;
   logic [23:0] pin_32to37_sel;
   logic [37:0] force_oeb;
   logic        busy, commit_done;
   logic [151:0] dut_sel;

   gpio_sel_sequencer #(.GUARD_CYCLES(G), .NUM_SRC(NSRC)) dut (
      .clk(clk), .rst(rst),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .pin_0to7_sel(pin_0to7_sel), .pin_8to15_sel(pin_8to15_sel),
      .pin_16to23_sel(pin_16to23_sel), .pin_24to31_sel(pin_24to31_sel),
      .pin_32to37_sel(pin_32to37_sel),
      .force_oeb(force_oeb), .busy(busy), .commit_done(commit_done)
   );

   always #5 clk = ~clk;

   assign dut_sel = {pin_32to37_sel, pin_24to31_sel, pin_16to23_sel, pin_8to15_sel, pin_0to7_sel};

   int checks = 0;
   int errors = 0;

   // Reference model: one source index per pin plus the status flags.
   int shadow_m[38];
   int active_m[38];
   bit err_range_m, err_busy_m, locked_m;

   task automatic check(input string tag, input logic [151:0] obs, input logic [151:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [151:0] pack(input bit use_shadow);
      logic [151:0] v;
      v = '0;
      for (int p = 0; p < 38; p++) v[4*p +: 4] = 4'(use_shadow ? shadow_m[p] : active_m[p]);
      return v;
   endfunction

   function automatic logic [31:0] sel_word(input int r);
      logic [151:0] v;
      v = pack(1'b1);
      if (r < 4) return v[32*r +: 32];
      return {8'h00, v[151:128]};
   endfunction

   function automatic logic [31:0] status_word();
      return {29'b0, err_range_m, err_busy_m, 1'b0};
   endfunction

   function automatic logic [31:0] rand_word(input bit bad);
      logic [31:0] w;
      int k;
      for (int i = 0; i < 8; i++) w[4*i +: 4] = 4'($urandom_range(0, NSRC - 1));
      if (bad) begin
         k = $urandom_range(0, 7);
         w[4*k +: 4] = 4'($urandom_range(NSRC, 15));
      end
      return w;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 38; p++) begin
         shadow_m[p] = 0;
         active_m[p] = 0;
      end
      err_range_m = 0;
      err_busy_m  = 0;
      locked_m    = 0;
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
      reg_addr  = a;
      reg_wdata = d;
      reg_wr    = 1'b1;
      @(negedge clk);
      reg_wr = 1'b0;
      check("wr_ack", reg_ack, 1'b1);
      check("wr_rdata_zero", reg_rdata, 32'h0);
   endtask

   task automatic reg_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
      reg_addr = a;
      reg_rd   = 1'b1;
      @(negedge clk);
      reg_rd = 1'b0;
      check({tag, "_ack"}, reg_ack, 1'b1);
      check(tag, reg_rdata, exp);
   endtask

   // Only called while the model knows the sequencer is idle.
   task automatic sel_write(input int r, input logic [31:0] d);
      reg_write(3'(r), d);
      if (locked_m) begin
         err_busy_m = 1;
      end else if (r < 4) begin
         for (int k = 0; k < 8; k++) shadow_m[8*r + k] = int'(d[4*k +: 4]);
      end else begin
         for (int k = 0; k < 6; k++) shadow_m[32 + k] = int'(d[4*k +: 4]);
      end
   endtask

   task automatic run_commit(input string tag);
      logic [151:0] old_act;
      logic [37:0]  mask;
      bit           bad;
      int           lat;
      old_act = pack(1'b0);
      bad = 0;
      for (int p = 0; p < 38; p++) begin
         mask[p] = (shadow_m[p] != active_m[p]);
         if (shadow_m[p] >= NSRC) bad = 1;
      end
      reg_write(3'd5, 32'h1);
      if (locked_m || bad) begin
         if (locked_m) err_busy_m = 1;
         else          err_range_m = 1;
         check({tag, "_rej_busy"}, busy, 1'b0);
         check({tag, "_rej_force"}, force_oeb, 38'h0);
         check({tag, "_rej_sel"}, dut_sel, old_act);
         reg_read(3'd6, status_word(), {tag, "_rej_status"});
         check({tag, "_rej_sel_after"}, dut_sel, old_act);
      end else begin
         lat = (mask == '0) ? 1 : G + 1;
         for (int k = 0; k < lat; k++) begin
            check({tag, "_seq_force"}, force_oeb, mask);
            check({tag, "_seq_busy"}, busy, 1'b1);
            check({tag, "_seq_done"}, commit_done, 1'b0);
            check({tag, "_seq_sel_old"}, dut_sel, old_act);
            @(negedge clk);
         end
         for (int p = 0; p < 38; p++) active_m[p] = shadow_m[p];
         check({tag, "_apply_sel"}, dut_sel, pack(1'b0));
         check({tag, "_apply_done"}, commit_done, 1'b1);
         check({tag, "_apply_force"}, force_oeb, 38'h0);
         check({tag, "_apply_busy"}, busy, 1'b0);
         @(negedge clk);
         check({tag, "_done_pulse"}, commit_done, 1'b0);
      end
   endtask

   initial begin
      int          nw, r;
      logic [31:0] d, old1;
      logic [37:0] mask;

      rst = 1'b1;
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      reg_addr = '0;
      reg_wdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_sel", dut_sel, '0);
      check("rst_force", force_oeb, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", commit_done, 1'b0);
      check("rst_ack", reg_ack, 1'b0);
      check("rst_rdata", reg_rdata, '0);
      rst = 1'b0;
      @(negedge clk);
      reg_read(3'd6, 32'h0, "rst_status");
      reg_read(3'd5, 32'h0, "rst_ctrl");

      // Pin 1 to source 3: pin 1 alone is guarded.
      sel_write(0, 32'h0000_0030);
      reg_read(3'd0, 32'h0000_0030, "sel0_rb");
      run_commit("pin1");

      // Nothing changed: straight to apply.
      run_commit("nochange");

      // Pin 37 out of range, then clear; a clear+commit re-flags.
      sel_write(4, 32'h00D0_0000);
      reg_read(3'd4, 32'h00D0_0000, "sel4_rb");
      run_commit("range");
      reg_write(3'd5, 32'h5);
      reg_read(3'd6, 32'h4, "clr_then_commit_status");
      reg_write(3'd5, 32'h4);
      err_range_m = 0;
      reg_read(3'd6, 32'h0, "cleared_status");
      sel_write(4, 32'h0000_0000);

      // Unmapped register and SEL4 upper byte.
      reg_write(3'd7, 32'hFFFF_FFFF);
      reg_read(3'd7, 32'h0, "reg7_rd");
      sel_write(4, 32'hFF0C_0C0C);
      reg_read(3'd4, 32'h000C_0C0C, "sel4_upper_zero");

      // Write and read strobed together: write wins, no read data.
      reg_addr  = 3'd3;
      reg_wdata = 32'h0000_0007;
      reg_wr    = 1'b1;
      reg_rd    = 1'b1;
      @(negedge clk);
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      check("wrrd_ack", reg_ack, 1'b1);
      check("wrrd_rdata", reg_rdata, 32'h0);
      for (int k = 0; k < 8; k++) shadow_m[24 + k] = (k == 0) ? 7 : 0;
      reg_read(3'd3, 32'h0000_0007, "wrrd_rb");
      run_commit("wrrd");

      // Writes and commit during a sequence are rejected.
      d = rand_word(1'b0);
      d[3:0] = 4'((active_m[0] + 1) % NSRC);
      sel_write(0, d);
      for (int p = 0; p < 38; p++) mask[p] = (shadow_m[p] != active_m[p]);
      old1 = sel_word(1);
      reg_write(3'd5, 32'h1);
      reg_write(3'd1, 32'h0A0B_0C01);
      check("busy_wr_force", force_oeb, mask);
      reg_write(3'd5, 32'h1);
      check("busy_commit_busy", busy, 1'b1);
      err_busy_m = 1;
      repeat (G - 1) @(negedge clk);
      for (int p = 0; p < 38; p++) active_m[p] = shadow_m[p];
      check("busy_done", commit_done, 1'b1);
      check("busy_sel", dut_sel, pack(1'b0));
      @(negedge clk);
      check("busy_no_second", busy, 1'b0);
      check("busy_done_low", commit_done, 1'b0);
      reg_read(3'd1, old1, "busy_sel1_rb");
      reg_read(3'd6, status_word(), "busy_status");
      reg_write(3'd5, 32'h4);
      err_busy_m = 0;
      reg_read(3'd6, 32'h0, "busy_cleared");

      // Randomized programming and commits.
      for (int it = 0; it < 12; it++) begin
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) begin
            r = $urandom_range(0, 4);
            d = rand_word($urandom_range(0, 7) == 0);
            sel_write(r, d);
            reg_read(3'(r), sel_word(r), "rnd_rb");
         end
         run_commit("rnd");
         if (err_range_m) begin
            reg_write(3'd5, 32'h4);
            err_range_m = 0;
            err_busy_m  = 0;
            for (int k = 0; k < 5; k++) sel_write(k, rand_word(1'b0));
         end
      end

      // Reset lands asynchronously in the middle of GUARD.
      d = pack(1'b1)[31:0];
      d[7:4] = 4'((active_m[1] + 5) % NSRC);
      sel_write(0, d);
      reg_write(3'd5, 32'h1);
      @(negedge clk);
      check("midrst_pre_busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("midrst_sel", dut_sel, '0);
      check("midrst_force", force_oeb, '0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", commit_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("midrst_after_sel", dut_sel, '0);
      reg_read(3'd0, 32'h0, "midrst_shadow");

`ifdef GPIO_SEL_LOCK_EN
      reg_write(3'd5, 32'h2);
      locked_m = 1;
      reg_read(3'd5, 32'h2, "lock_ctrl");
      sel_write(2, 32'h1111_1111);
      reg_read(3'd2, 32'h0, "lock_sel2_rb");
      run_commit("lock");
      reg_read(3'd6, 32'h2, "lock_status");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
